// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline flow controller.
// State, redirect-kind encodings and mcause values used by the controller and its redirect buffer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    RDR_PEND = 2'd2
  } flow_state_e;

  typedef enum logic {
    RDR_BR   = 1'b0,
    RDR_TRAP = 1'b1
  } rdr_kind_e;

  localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
  localparam logic [31:0] CAUSE_MEXT_IRQ = 32'h8000_000B;

endpackage

// File: rtl/pipe_flow_ctrl_redirect_buf.sv
// One-entry redirect buffer: holds kind and target of a redirect raised while imem is not ready.
// Loads on the event cycle, drops on clear; load wins if both are seen together.
module redirect_buf
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  rdr_kind_e       kind_in,
  input  logic [XLEN-1:0] tgt_in,
  output logic            vld,
  output rdr_kind_e       kind,
  output logic [XLEN-1:0] tgt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld  <= 1'b0;
      kind <= RDR_BR;
      tgt  <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      kind <= kind_in;
      tgt  <= tgt_in;
    end else if (clear) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: PC stall/redirect, IF/DE and DE/EX flush/stall, trap entry and mret.
// Zero-cycle latency in RUN; redirects wait on imem readiness; interrupt path under PIPE_IRQ_EN.
module pipe_flow_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              LOAD_STALL_CYC = 1,
  parameter logic [XLEN-1:0] EXC_CAUSE      = XLEN'(CAUSE_ILLEGAL)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_tgt_i,
  input  logic            exc_i,
  input  logic            irq_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] pc_ex_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            load_use_i,
  input  logic            imem_ready_i,
  output logic            pc_stall_o,
  output logic            pc_br_o,
  output logic [XLEN-1:0] pc_br_tgt_o,
  output logic            pc_trap_o,
  output logic [XLEN-1:0] pc_vec_o,
  output logic            flush_if_o,
  output logic            flush_de_o,
  output logic            stall_de_o,
  output logic            epc_we_o,
  output logic [XLEN-1:0] epc_wdata_o,
  output logic [XLEN-1:0] cause_o,
  output logic            in_handler_o
);

  flow_state_e     state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            in_handler_q, in_handler_d;
  logic            rdr_ev;
  rdr_kind_e       ev_kind, buf_kind;
  logic [XLEN-1:0] ev_tgt, buf_tgt;
  logic            buf_load, buf_clear, buf_vld;
  logic            irq_take;

`ifdef PIPE_IRQ_EN
  assign irq_take = irq_i & ~in_handler_q;
`else
  logic unused_irq;
  assign unused_irq = irq_i;
  assign irq_take   = 1'b0;
`endif

  redirect_buf #(.XLEN(XLEN)) u_rdr_buf (
    .clk     (clk),
    .reset   (reset),
    .load    (buf_load),
    .clear   (buf_clear),
    .kind_in (ev_kind),
    .tgt_in  (ev_tgt),
    .vld     (buf_vld),
    .kind    (buf_kind),
    .tgt     (buf_tgt)
  );

  always_comb begin
    pc_stall_o   = 1'b0;
    pc_br_o      = 1'b0;
    pc_br_tgt_o  = '0;
    pc_trap_o    = 1'b0;
    pc_vec_o     = '0;
    flush_if_o   = 1'b0;
    flush_de_o   = 1'b0;
    stall_de_o   = 1'b0;
    epc_we_o     = 1'b0;
    epc_wdata_o  = '0;
    cause_o      = '0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    in_handler_d = in_handler_q;
    rdr_ev       = 1'b0;
    ev_kind      = RDR_BR;
    ev_tgt       = '0;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;

    // Outputs are held quiet during reset so a pending redirect is never issued.
    if (!reset) begin
      unique case (state_q)
        RUN: begin
          if (exc_i || irq_take) begin
            rdr_ev       = 1'b1;
            ev_kind      = RDR_TRAP;
            ev_tgt       = mtvec_i;
            epc_we_o     = 1'b1;
            epc_wdata_o  = pc_ex_i;
            cause_o      = exc_i ? EXC_CAUSE : XLEN'(CAUSE_MEXT_IRQ);
            in_handler_d = 1'b1;
          end else if (mret_i) begin
            rdr_ev       = 1'b1;
            ev_kind      = RDR_TRAP;
            ev_tgt       = mepc_i;
            in_handler_d = 1'b0;
          end else if (br_taken_i) begin
            rdr_ev  = 1'b1;
            ev_kind = RDR_BR;
            ev_tgt  = br_tgt_i;
          end else if (load_use_i) begin
            pc_stall_o = 1'b1;
            stall_de_o = 1'b1;
            flush_de_o = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
              state_d = LU_STALL;
              cnt_d   = 3'(LOAD_STALL_CYC - 1);
            end
          end else if (!imem_ready_i) begin
            pc_stall_o = 1'b1;
            flush_if_o = 1'b1;
          end

          if (rdr_ev) begin
            flush_if_o = 1'b1;
            flush_de_o = 1'b1;
            if (imem_ready_i) begin
              pc_trap_o   = (ev_kind == RDR_TRAP);
              pc_vec_o    = (ev_kind == RDR_TRAP) ? ev_tgt : '0;
              pc_br_o     = (ev_kind == RDR_BR);
              pc_br_tgt_o = (ev_kind == RDR_BR) ? ev_tgt : '0;
            end else begin
              pc_stall_o = 1'b1;
              buf_load   = 1'b1;
              state_d    = RDR_PEND;
            end
          end
        end

        LU_STALL: begin
          pc_stall_o = 1'b1;
          stall_de_o = 1'b1;
          flush_de_o = 1'b1;
          cnt_d      = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = RUN;
          end
        end

        RDR_PEND: begin
          if (imem_ready_i && buf_vld) begin
            flush_if_o  = 1'b1;
            flush_de_o  = 1'b1;
            pc_trap_o   = (buf_kind == RDR_TRAP);
            pc_vec_o    = (buf_kind == RDR_TRAP) ? buf_tgt : '0;
            pc_br_o     = (buf_kind == RDR_BR);
            pc_br_tgt_o = (buf_kind == RDR_BR) ? buf_tgt : '0;
            buf_clear   = 1'b1;
            state_d     = RUN;
          end else begin
            pc_stall_o = 1'b1;
            flush_if_o = 1'b1;
          end
        end

        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= 3'd0;
      in_handler_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in_handler_q <= in_handler_d;
    end
  end

  assign in_handler_o = in_handler_q;

endmodule

// File: doc/pipe_flow_ctrl.md
# pipe_flow_ctrl

Pipeline flow controller for the 3-stage RV32I core. Sits between EX-stage event sources (branch resolution, exceptions, `mret`, interrupts), the load-use hazard detector and instruction-memory readiness. Sequences the Program_Counter's stall and redirect inputs and the IF/DE and DE/EX flush and stall controls. Owns the trap-entry handshake with the CSR file (mepc write and cause) and the in-handler interrupt mask.

## Interface
Parameters:
- `XLEN`, 32, datapath and PC width.
- `LOAD_STALL_CYC`, 1, number of bubble cycles per load-use hazard (1..7).
- `EXC_CAUSE`, 32'd2, mcause value written for an EX-stage exception (illegal instruction).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `br_taken_i`  in  1  branch or jump taken in EX.
- `br_tgt_i`  in  XLEN  branch or jump target.
- `exc_i`  in  1  exception raised by the instruction in EX.
- `irq_i`  in  1  level interrupt request, already enabled and masked by CSRs.
- `mret_i`  in  1  `mret` in EX.
- `pc_ex_i`  in  XLEN  PC of the instruction in EX.
- `mtvec_i`, `mepc_i`  in  XLEN  trap vector and return address from the CSR file.
- `load_use_i`  in  1  load in EX feeds a source operand of the instruction in DE.
- `imem_ready_i`  in  1  instruction memory returns valid data this cycle.
- `pc_stall_o`  out  1  hold the PC.
- `pc_br_o`  out  1  load `pc_br_tgt_o` into the PC.
- `pc_br_tgt_o`  out  XLEN  branch target to the PC.
- `pc_trap_o`  out  1  load `pc_vec_o` into the PC.
- `pc_vec_o`  out  XLEN  trap vector or `mepc`.
- `flush_if_o`  out  1  write a NOP into the IF/DE register.
- `flush_de_o`  out  1  write a NOP into the DE/EX register.
- `stall_de_o`  out  1  hold the IF/DE register.
- `epc_we_o`  out  1  mepc/mcause write strobe.
- `epc_wdata_o`  out  XLEN  value written to mepc.
- `cause_o`  out  XLEN  value written to mcause.
- `in_handler_o`  out  1  trap handler active.

## Operation
- **Event priority in RUN:** `exc_i` > `irq_i` (only when `!in_handler`) > `mret_i` > `br_taken_i` > `load_use_i` > `!imem_ready_i`.
- **Trap** (exc or irq):
  - Assert `epc_we_o`, `epc_wdata_o = pc_ex_i`.
  - `cause_o = EXC_CAUSE` for an exception, `32'h8000000B` for an interrupt.
  - Redirect to `mtvec_i`.
  - Set `in_handler`.
  - A nested exception is still taken; `in_handler` stays 1.
- **mret:** redirect to `mepc_i`, clear `in_handler`.
- **Redirect:**
  - Trap and `mret` use `pc_trap_o`/`pc_vec_o`; branch uses `pc_br_o`/`pc_br_tgt_o`.
  - Assert `flush_if_o` and `flush_de_o` in the same cycle.
- **Load-use:** assert `pc_stall_o`, `stall_de_o` and `flush_de_o` (bubble into EX) for exactly `LOAD_STALL_CYC` cycles.
- **Fetch miss** (`!imem_ready_i`, no other event): `pc_stall_o=1`, `flush_if_o=1`.
- **FSM states:**
  - RUN: normal operation, default after reset.
  - LU_STALL: counting down the load-use bubbles.
  - RDR_PEND: a redirect is buffered while waiting on instruction memory.
- **FSM transitions:**
  - RUN→LU_STALL when a load-use hazard hits and `LOAD_STALL_CYC>1`. The down-counter loads `LOAD_STALL_CYC-1`; leave LU_STALL when it reaches 0.
  - RUN→RDR_PEND when a redirect event hits while `imem_ready_i=0`:
    - Latch the kind (branch or trap) and the target.
    - Trap side effects (epc write, `in_handler`) happen in the event cycle.
    - Flush IF/DE and DE/EX in the event cycle.
  - In RDR_PEND: `pc_stall_o=1`, `flush_if_o=1`. When `imem_ready_i=1`, drive the buffered redirect, then RDR_PEND→RUN.
- **Ignored inputs:** all EX event inputs in LU_STALL and RDR_PEND (EX holds a bubble).

## Timing
- Redirect, flush, stall and epc outputs are combinational from inputs and state in RUN, so the PC updates on the next edge (zero-cycle controller latency).
- Buffered redirect latency equals the number of `imem_ready_i=0` cycles.
- Reset values: all outputs 0, targets 0, state RUN, `in_handler=0`, counter 0.
- Reset mid-operation discards any pending redirect or stall with no redirect issued.
- `in_handler_o` is registered and updates the edge after the trap or `mret` cycle.

## Configuration
- `PIPE_IRQ_EN` defined: interrupt path compiled in as above.
- `PIPE_IRQ_EN` undefined:
  - `irq_i` is ignored.
  - `cause_o` is always `EXC_CAUSE`.
  - `in_handler` still tracks exceptions and `mret`.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - state enum `flow_state_e` {RUN, LU_STALL, RDR_PEND};
  - redirect kind enum `rdr_kind_e` {RDR_BR, RDR_TRAP};
  - constants `CAUSE_ILLEGAL`, `CAUSE_MEXT_IRQ`.
- Sub-module `redirect_buf`: a one-entry buffer holding valid, kind and target, with load and clear. It captures a redirect in the event cycle and releases it when `imem_ready_i` is high.

## Test plan
- Reset then idle, `imem_ready_i=1`, no events → all outputs 0 and state RUN on every cycle.
- `br_taken_i=1`, `br_tgt_i=0x100` → same cycle `pc_br_o=1`, `pc_br_tgt_o=0x100`, `flush_if_o=flush_de_o=1`; a simultaneous `load_use_i` produces no stall.
- `exc_i=1`, `pc_ex_i=0x40`, `mtvec_i=0x200` → `epc_we_o=1`, `epc_wdata_o=0x40`, `cause_o=2`, `pc_trap_o=1`, `pc_vec_o=0x200`, and `in_handler_o=1` next cycle. Then `irq_i=1` is ignored. Then `mret_i=1` with `mepc_i=0x44` → `pc_vec_o=0x44`, and `in_handler_o=0` next cycle.
- `br_taken_i=1`, target 0x80, with `imem_ready_i=0` for 3 cycles → flushes in cycle 0, `pc_stall_o=1` for 3 cycles, then `pc_br_o=1` with 0x80 in the cycle `imem_ready_i` rises.
- `LOAD_STALL_CYC=2`, `load_use_i` pulse → `pc_stall_o`, `stall_de_o`, `flush_de_o` high for exactly 2 cycles.
- `reset` asserted in RDR_PEND → next cycle state RUN and no `pc_br_o`/`pc_trap_o` issued. With `PIPE_IRQ_EN` undefined, `irq_i=1` → no trap.
